// File: rtl/jtframe_credits_ctrl.sv
// rtl/jtframe_credits_ctrl.sv - credits overlay sequencer (fade-in / scroll / fade-out)
//
// Purpose: counts video frames from VB rising edges and steps the credits overlay
// through IDLE -> FADE_IN -> SCROLL -> FADE_OUT -> IDLE, following the game's pause
// request. All outputs update once per frame tick.
//
// Optional feature macro: JTFRAME_CREDITS_HOLD_EN adds a HOLD state that pauses the
// scroll at every page boundary for HOLD_FRAMES ticks.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active high
//   pxl_cen   in   pixel clock enable
//   HB        in   horizontal blank, passed through to HB_out
//   VB        in   vertical blank, frame tick on its rising edge
//   pause_req in   level, game requests credits display
//   skip      in   one-clk pulse, jump to start of next page
//   HB_out    out  horizontal blank pass-through
//   enable    out  overlay enable
//   fade      out  overlay intensity, 0 = invisible, 15 = full
//   scroll    out  line offset inside current page
//   page      out  current page index
//   busy      out  high in any state other than IDLE
module jtframe_credits_ctrl #(
  parameter int PAGES       = 3,
  parameter int SPEED       = 2,
  parameter int HOLD_FRAMES = 60,
  localparam int PW         = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          HB,
  input  logic          VB,
  input  logic          pause_req,
  input  logic          skip,
  output logic          HB_out,
  output logic          enable,
  output logic [3:0]    fade,
  output logic [7:0]    scroll,
  output logic [PW-1:0] page,
  output logic          busy
);

  localparam int SW = (SPEED > 1) ? $clog2(SPEED) : 1;

`ifdef JTFRAME_CREDITS_HOLD_EN
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  typedef enum logic [2:0] {IDLE, FADE_IN, SCROLL, FADE_OUT, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, FADE_IN, SCROLL, FADE_OUT} state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    fade_d;
  logic [7:0]    scroll_d;
  logic [PW-1:0] page_d, page_inc;
  logic [SW-1:0] spd_q, spd_d;
  logic          skip_l, skip_d, skip_ok, skip_now;
  logic          vb_l, tick;
`ifdef JTFRAME_CREDITS_HOLD_EN
  logic [HW-1:0] hold_q, hold_d;
`endif

  assign HB_out = HB;
  assign tick   = pxl_cen & VB & ~vb_l;

`ifdef JTFRAME_CREDITS_HOLD_EN
  assign skip_ok = (state_q == SCROLL) || (state_q == HOLD);
`else
  assign skip_ok = (state_q == SCROLL);
`endif

  // A skip arriving on the tick cycle itself is honoured as if it had been latched.
  assign skip_now = skip_l | (skip & skip_ok);
  assign page_inc = (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;

  always_comb begin
    state_d  = state_q;
    fade_d   = fade;
    scroll_d = scroll;
    page_d   = page;
    spd_d    = spd_q;
    skip_d   = skip_l;
`ifdef JTFRAME_CREDITS_HOLD_EN
    hold_d   = hold_q;
`endif
    if (tick) skip_d = 1'b0;
    else if (skip && skip_ok) skip_d = 1'b1;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (pause_req) begin
            state_d = FADE_IN;
            fade_d  = 4'd1;
          end
        end
        FADE_IN: begin
          if (!pause_req) begin
            state_d = FADE_OUT;
          end else begin
            if (fade != 4'd15) fade_d = fade + 4'd1;
            if (fade >= 4'd14) state_d = SCROLL;
          end
        end
        SCROLL: begin
          if (!pause_req) begin
            state_d = FADE_OUT;
          end else if (skip_now) begin
            scroll_d = 8'd0;
            page_d   = page_inc;
            spd_d    = '0;
`ifdef JTFRAME_CREDITS_HOLD_EN
            state_d  = HOLD;
            hold_d   = '0;
`endif
          end else if (spd_q == SW'(SPEED - 1)) begin
            spd_d    = '0;
            scroll_d = scroll + 8'd1;
            if (scroll == 8'd255) begin
              page_d = page_inc;
`ifdef JTFRAME_CREDITS_HOLD_EN
              state_d = HOLD;
              hold_d  = '0;
`endif
            end
          end else begin
            spd_d = spd_q + 1'b1;
          end
        end
        FADE_OUT: begin
          if (pause_req && fade != 4'd0) begin
            state_d = FADE_IN;
          end else begin
            if (fade != 4'd0) fade_d = fade - 4'd1;
            if (fade <= 4'd1) begin
              state_d  = IDLE;
              scroll_d = 8'd0;
              page_d   = '0;
              spd_d    = '0;
            end
          end
        end
`ifdef JTFRAME_CREDITS_HOLD_EN
        HOLD: begin
          if (!pause_req) begin
            state_d = FADE_OUT;
          end else if (skip_now) begin
            page_d  = page_inc;
            spd_d   = '0;
            state_d = SCROLL;
          end else if (hold_q == HW'(HOLD_FRAMES - 1)) begin
            spd_d   = '0;
            state_d = SCROLL;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      enable  <= 1'b0;
      busy    <= 1'b0;
      fade    <= 4'd0;
      scroll  <= 8'd0;
      page    <= '0;
      spd_q   <= '0;
      skip_l  <= 1'b0;
      vb_l    <= 1'b0;
`ifdef JTFRAME_CREDITS_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      if (pxl_cen) vb_l <= VB;
      state_q <= state_d;
      enable  <= (state_d != IDLE);
      busy    <= (state_d != IDLE);
      fade    <= fade_d;
      scroll  <= scroll_d;
      page    <= page_d;
      spd_q   <= spd_d;
      skip_l  <= skip_d;
`ifdef JTFRAME_CREDITS_HOLD_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtframe_credits_ctrl.sv
// tb/tb_jtframe_credits_ctrl.sv - directed self-checking bench for jtframe_credits_ctrl
module tb_jtframe_credits_ctrl;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, HB, VB, pause_req, skip;
  logic       HB_out, enable, busy;
  logic [3:0] fade;
  logic [7:0] scroll;
  logic [1:0] page;
  int         n_checks = 0;
  int         n_fail   = 0;

  jtframe_credits_ctrl #(.PAGES(3), .SPEED(2), .HOLD_FRAMES(60)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .HB(HB), .VB(VB),
    .pause_req(pause_req), .skip(skip), .HB_out(HB_out), .enable(enable),
    .fade(fade), .scroll(scroll), .page(page), .busy(busy)
  );

  always #5 clk = ~clk;

  // One VB pulse with pxl_cen held high; outputs sampled on the falling edge.
  task automatic frame();
    @(negedge clk) VB = 1'b1;
    @(negedge clk) VB = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic chk_all(input string name, input logic en, input logic [3:0] f,
                         input logic [7:0] s, input logic [1:0] p, input logic b);
    n_checks++;
    if (enable !== en || fade !== f || scroll !== s || page !== p || busy !== b) begin
      n_fail++;
      $display("FAIL %s: got en=%b fade=%0d scroll=%0d page=%0d busy=%b, want en=%b fade=%0d scroll=%0d page=%0d busy=%b",
               name, enable, fade, scroll, page, busy, en, f, s, p, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pxl_cen = 1'b1; HB = 1'b0; VB = 1'b0; pause_req = 1'b0; skip = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all("reset", 1'b0, 4'd0, 8'd0, 2'd0, 1'b0);
    HB = 1'b1;
    #1;
    n_checks++;
    if (HB_out !== 1'b1) begin
      n_fail++;
      $display("FAIL hb_pass: got %b want 1", HB_out);
    end
    HB = 1'b0;
    frames(3);
    chk_all("idle_no_req", 1'b0, 4'd0, 8'd0, 2'd0, 1'b0);
  endtask

  // 4 VB pulses 32 clocks wide with pxl_cen on alternate clocks -> exactly 4 ticks.
  task automatic test_tick();
    pause_req = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        VB = (c < 32);
        pxl_cen = c[0];
      end
    end
    @(negedge clk) pxl_cen = 1'b1; VB = 1'b0;
    @(negedge clk);
    chk_all("tick_4_pulses", 1'b1, 4'd4, 8'd0, 2'd0, 1'b1);
    VB = 1'b1;
    repeat (100) @(negedge clk);
    VB = 1'b0;
    @(negedge clk);
    chk_all("tick_vb_held", 1'b1, 4'd5, 8'd0, 2'd0, 1'b1);
    pxl_cen = 1'b0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk) VB = 1'b1;
      @(negedge clk) VB = 1'b0;
    end
    @(negedge clk);
    chk_all("tick_no_cen", 1'b1, 4'd5, 8'd0, 2'd0, 1'b1);
    pxl_cen = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fade_in();
    for (int f = 6; f <= 15; f++) begin
      frame();
      n_checks++;
      if (fade !== 4'(f) || enable !== 1'b1) begin
        n_fail++;
        $display("FAIL fade_in_%0d: got fade=%0d en=%b want fade=%0d en=1", f, fade, enable, f);
      end
    end
  endtask

  task automatic test_scroll();
    frames(2);
    chk_all("scroll_first_step", 1'b1, 4'd15, 8'd1, 2'd0, 1'b1);
    frames(509);
    chk_all("scroll_255", 1'b1, 4'd15, 8'd255, 2'd0, 1'b1);
    frame();
    chk_all("scroll_page1", 1'b1, 4'd15, 8'd0, 2'd1, 1'b1);
    frames(1023);
    chk_all("scroll_page2_end", 1'b1, 4'd15, 8'd255, 2'd2, 1'b1);
    frame();
    chk_all("scroll_page_wrap", 1'b1, 4'd15, 8'd0, 2'd0, 1'b1);
  endtask

  task automatic test_skip();
    frames(1024 + 200);
    chk_all("skip_pre", 1'b1, 4'd15, 8'd100, 2'd2, 1'b1);
    @(negedge clk) skip = 1'b1;
    @(negedge clk) skip = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("skip_latched_wait", 1'b1, 4'd15, 8'd100, 2'd2, 1'b1);
    frame();
    chk_all("skip_applied", 1'b1, 4'd15, 8'd0, 2'd0, 1'b1);
    frames(2);
    chk_all("skip_resume", 1'b1, 4'd15, 8'd1, 2'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    frames(510 + 80);
    chk_all("mid_pre", 1'b1, 4'd15, 8'd40, 2'd1, 1'b1);
    pxl_cen = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk_all("mid_reset", 1'b0, 4'd0, 8'd0, 2'd0, 1'b0);
    rst = 1'b0; pxl_cen = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    pause_req = 1'b1;
    frames(7);
    chk_all("abort_fade7", 1'b1, 4'd7, 8'd0, 2'd0, 1'b1);
    pause_req = 1'b0;
    frame();
    chk_all("abort_turn", 1'b1, 4'd7, 8'd0, 2'd0, 1'b1);
    frames(4);
    chk_all("abort_fade3", 1'b1, 4'd3, 8'd0, 2'd0, 1'b1);
    pause_req = 1'b1;
    frame();
    chk_all("rereq_turn", 1'b1, 4'd3, 8'd0, 2'd0, 1'b1);
    frames(2);
    chk_all("rereq_fade5", 1'b1, 4'd5, 8'd0, 2'd0, 1'b1);
    pause_req = 1'b0;
    frames(5);
    chk_all("abort_fade1", 1'b1, 4'd1, 8'd0, 2'd0, 1'b1);
    frame();
    chk_all("abort_idle", 1'b0, 4'd0, 8'd0, 2'd0, 1'b0);
    frames(2);
    chk_all("idle_hold", 1'b0, 4'd0, 8'd0, 2'd0, 1'b0);
  endtask

  task automatic test_skip_idle();
    @(negedge clk) skip = 1'b1;
    @(negedge clk) skip = 1'b0;
    frame();
    chk_all("skip_idle", 1'b0, 4'd0, 8'd0, 2'd0, 1'b0);
    pause_req = 1'b1;
    frames(15);
    chk_all("skip_idle_full", 1'b1, 4'd15, 8'd0, 2'd0, 1'b1);
    frames(2);
    chk_all("skip_idle_noqueue", 1'b1, 4'd15, 8'd1, 2'd0, 1'b1);
    // Dropping pause_req wins over a pending skip in SCROLL.
    @(negedge clk) skip = 1'b1;
    @(negedge clk) skip = 1'b0;
    pause_req = 1'b0;
    frame();
    chk_all("out_over_skip", 1'b1, 4'd15, 8'd1, 2'd0, 1'b1);
    frame();
    chk_all("out_first_step", 1'b1, 4'd14, 8'd1, 2'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_tick();
    test_fade_in();
    test_scroll();
    test_skip();
    test_reset_mid();
    test_abort();
    test_skip_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
